// File: rtl/edge_sense_multi.sv
// Multi-channel edge detector: synchroniser, glitch filter, rising/falling edge pulses,
// mode-selected stretched event pulse and sticky pending flag per channel, plus irq.
module edge_sense_multi #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int PULSE_LEN   = 4
) (
  input  logic                    clk,
  input  logic                    clrn,
  input  logic [CHANNELS-1:0]     d,
  input  logic [2*CHANNELS-1:0]   mode,
  input  logic [CHANNELS-1:0]     clr,
  output logic [CHANNELS-1:0]     level,
  output logic [CHANNELS-1:0]     q_r,
  output logic [CHANNELS-1:0]     q_f,
  output logic [CHANNELS-1:0]     evt,
  output logic [CHANNELS-1:0]     pend,
  output logic                    irq
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam int PW = $clog2(PULSE_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);
  localparam logic [PW-1:0] PC_LOAD  = PW'(PULSE_LEN);

  logic [SYNC_STAGES-1:0] sync_p0 [CHANNELS];
  logic [CW-1:0]          cnt_p1  [CHANNELS];
  logic [PW-1:0]          pc_p2   [CHANNELS];

  logic [CHANNELS-1:0] s;
  logic [CHANNELS-1:0] level_next;
  logic [CHANNELS-1:0] q_r_next;
  logic [CHANNELS-1:0] q_f_next;
  logic [CHANNELS-1:0] sel;
  logic [CW-1:0]       cnt_next [CHANNELS];
  logic [PW-1:0]       pc_next  [CHANNELS];

  // A retrigger reloads the full length, so overlapping events merge into one pulse.
  function automatic logic [PW-1:0] pc_step(input logic load, input logic [PW-1:0] pc);
    if (load)
      return PC_LOAD;
    else if (pc != '0)
      return pc - PW'(1);
    else
      return '0;
  endfunction

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      // Filter stage: a new level must persist FILTER_LEN consecutive cycles
      s[i]          = sync_p0[i][SYNC_STAGES-1];
      level_next[i] = level[i];
      cnt_next[i]   = '0;
      if (s[i] != level[i]) begin
        if (cnt_p1[i] == CNT_LAST)
          level_next[i] = s[i];
        else
          cnt_next[i] = cnt_p1[i] + CW'(1);
      end
      // Edge/select stage
      q_r_next[i] = ~level[i] & level_next[i];
      q_f_next[i] = level[i] & ~level_next[i];
      sel[i]      = (q_r_next[i] & mode[2*i]) | (q_f_next[i] & mode[2*i+1]);
      pc_next[i]  = pc_step(sel[i], pc_p2[i]);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < CHANNELS; i++) begin
        sync_p0[i] <= '0;
        cnt_p1[i]  <= '0;
        pc_p2[i]   <= '0;
      end
      level <= '0;
      q_r   <= '0;
      q_f   <= '0;
      evt   <= '0;
      pend  <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        sync_p0[i] <= {sync_p0[i][SYNC_STAGES-2:0], d[i]};
        cnt_p1[i]  <= cnt_next[i];
        pc_p2[i]   <= pc_next[i];
        evt[i]     <= (pc_next[i] != '0);
      end
      level <= level_next;
      q_r   <= q_r_next;
      q_f   <= q_f_next;
      // A new event wins over a simultaneous clear
      pend  <= sel | (pend & ~clr);
    end
  end

  assign irq = |pend;

endmodule
